// File: rtl/mips_defs.sv
// Shared MIPS definitions: opcodes, funct codes, ALU codes, control states.
// Opcode support depends on UNIDADE_CONTROLE_BNE_EN.
package mips_defs;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;
  localparam logic [5:0] F_NOR = 6'b100111;

  localparam logic [3:0] ULA_AND = 4'b0000;
  localparam logic [3:0] ULA_OR  = 4'b0001;
  localparam logic [3:0] ULA_ADD = 4'b0010;
  localparam logic [3:0] ULA_SUB = 4'b0011;
  localparam logic [3:0] ULA_SLT = 4'b0100;
  localparam logic [3:0] ULA_NOR = 4'b0101;

  typedef enum logic [3:0] {
    EST_BUSCA        = 4'd0,
    EST_DECODIFICA   = 4'd1,
    EST_ENDMEM       = 4'd2,
    EST_LE_MEM       = 4'd3,
    EST_ESCR_REG_MEM = 4'd4,
    EST_ESCR_MEM     = 4'd5,
    EST_EXEC_R       = 4'd6,
    EST_FIM_R        = 4'd7,
    EST_EXEC_I       = 4'd8,
    EST_FIM_I        = 4'd9,
    EST_DESVIO       = 4'd10,
    EST_SALTO        = 4'd11,
    EST_DESVIO_NE    = 4'd12
  } estado_t;

  function automatic logic opcodeSuportado(input logic [5:0] op);
    logic ok;
    ok = (op == OP_R) || (op == OP_LW) || (op == OP_SW) ||
         (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI);
`ifdef UNIDADE_CONTROLE_BNE_EN
    ok = ok || (op == OP_BNE);
`endif
    return ok;
  endfunction

endpackage

// File: rtl/decodifica_funct.sv
// Combinational funct -> ALU operation decode for R-type instructions.
// Unknown funct falls back to ADD and raises invalido.
module decodifica_funct
  import mips_defs::*;
(
  input  logic [5:0] funct,
  output logic [3:0] codigo,
  output logic       invalido
);

  always_comb begin
    codigo   = ULA_ADD;
    invalido = 1'b0;
    unique case (1'b1)
      (funct == F_ADD): codigo = ULA_ADD;
      (funct == F_SUB): codigo = ULA_SUB;
      (funct == F_AND): codigo = ULA_AND;
      (funct == F_OR):  codigo = ULA_OR;
      (funct == F_SLT): codigo = ULA_SLT;
      (funct == F_NOR): codigo = ULA_NOR;
      default:          invalido = 1'b1;
    endcase
  end

endmodule

// File: rtl/unidade_controle_multiciclo.sv
// Multi-cycle MIPS control FSM driving datapath enables and ALU select.
// Define UNIDADE_CONTROLE_BNE_EN to add bne support.
module unidade_controle_multiciclo
  import mips_defs::*;
#(
  parameter int LARGURA_ESTADO = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [0:5] opcode,
  input  logic [0:5] funct,
  input  logic       zero,
  output logic       escritaPC,
  output logic       iouD,
  output logic       leMem,
  output logic       escreveMem,
  output logic       escreveIR,
  output logic       memParaReg,
  output logic       regDst,
  output logic       escreveReg,
  output logic       fonteA,
  output logic [0:1] fonteB,
  output logic [0:1] fontePC,
  output logic [0:3] unidadeControle,
  output logic       instrInvalida
);

  logic [LARGURA_ESTADO-1:0] estado;
  logic                      ehLw;
  logic                      functRuim;
  logic [3:0]                codigoR;
  logic                      invR;

  decodifica_funct uDecFunct (
    .funct    (funct),
    .codigo   (codigoR),
    .invalido (invR)
  );

  // lw/sw choice and bad funct are latched so later opcode/funct changes are ignored
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado    <= EST_BUSCA;
      ehLw      <= 1'b0;
      functRuim <= 1'b0;
    end else begin
      case (estado)
        EST_BUSCA: estado <= EST_DECODIFICA;
        EST_DECODIFICA: begin
          ehLw <= (opcode == OP_LW);
          case (opcode)
            OP_LW, OP_SW: estado <= EST_ENDMEM;
            OP_R:         estado <= EST_EXEC_R;
            OP_BEQ:       estado <= EST_DESVIO;
`ifdef UNIDADE_CONTROLE_BNE_EN
            OP_BNE:       estado <= EST_DESVIO_NE;
`endif
            OP_J:         estado <= EST_SALTO;
            OP_ADDI:      estado <= EST_EXEC_I;
            default:      estado <= EST_BUSCA;
          endcase
        end
        EST_ENDMEM:
          estado <= ehLw ? EST_LE_MEM : EST_ESCR_MEM;
        EST_LE_MEM:       estado <= EST_ESCR_REG_MEM;
        EST_ESCR_REG_MEM: estado <= EST_BUSCA;
        EST_ESCR_MEM:     estado <= EST_BUSCA;
        EST_EXEC_R: begin
          functRuim <= invR;
          estado    <= EST_FIM_R;
        end
        EST_FIM_R:        estado <= EST_BUSCA;
        EST_EXEC_I:       estado <= EST_FIM_I;
        EST_FIM_I:        estado <= EST_BUSCA;
        EST_DESVIO:       estado <= EST_BUSCA;
`ifdef UNIDADE_CONTROLE_BNE_EN
        EST_DESVIO_NE:    estado <= EST_BUSCA;
`endif
        EST_SALTO:        estado <= EST_BUSCA;
        default:          estado <= EST_BUSCA;
      endcase
    end
  end

  always_comb begin
    escritaPC       = 1'b0;
    iouD            = 1'b0;
    leMem           = 1'b0;
    escreveMem      = 1'b0;
    escreveIR       = 1'b0;
    memParaReg      = 1'b0;
    regDst          = 1'b0;
    escreveReg      = 1'b0;
    fonteA          = 1'b0;
    fonteB          = 2'b00;
    fontePC         = 2'b00;
    unidadeControle = ULA_AND;
    instrInvalida   = 1'b0;
    if (!reset) begin
      case (estado)
        EST_BUSCA: begin
          leMem           = 1'b1;
          escreveIR       = 1'b1;
          fonteB          = 2'b01;
          unidadeControle = ULA_ADD;
          escritaPC       = 1'b1;
        end
        EST_DECODIFICA: begin
          fonteB          = 2'b11;
          unidadeControle = ULA_ADD;
          instrInvalida   = !opcodeSuportado(opcode);
        end
        EST_ENDMEM: begin
          fonteA          = 1'b1;
          fonteB          = 2'b10;
          unidadeControle = ULA_ADD;
        end
        EST_LE_MEM: begin
          iouD  = 1'b1;
          leMem = 1'b1;
        end
        EST_ESCR_REG_MEM: begin
          escreveReg = 1'b1;
          memParaReg = 1'b1;
        end
        EST_ESCR_MEM: begin
          iouD       = 1'b1;
          escreveMem = 1'b1;
        end
        EST_EXEC_R: begin
          fonteA          = 1'b1;
          unidadeControle = codigoR;
        end
        EST_FIM_R: begin
          regDst        = 1'b1;
          escreveReg    = !functRuim;
          instrInvalida = functRuim;
        end
        EST_EXEC_I: begin
          fonteA          = 1'b1;
          fonteB          = 2'b10;
          unidadeControle = ULA_ADD;
        end
        EST_FIM_I: escreveReg = 1'b1;
        EST_DESVIO: begin
          fonteA          = 1'b1;
          unidadeControle = ULA_SUB;
          fontePC         = 2'b01;
          escritaPC       = zero;
        end
`ifdef UNIDADE_CONTROLE_BNE_EN
        EST_DESVIO_NE: begin
          fonteA          = 1'b1;
          unidadeControle = ULA_SUB;
          fontePC         = 2'b01;
          escritaPC       = !zero;
        end
`endif
        EST_SALTO: begin
          fontePC   = 2'b10;
          escritaPC = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_unidade_controle_multiciclo.sv
// Directed bench for the multi-cycle control unit with an instruction-level model.
// Model honours UNIDADE_CONTROLE_BNE_EN the same way as the design build.
module tb_unidade_controle_multiciclo;

`ifdef UNIDADE_CONTROLE_BNE_EN
  localparam bit BNE = 1'b1;
`else
  localparam bit BNE = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [0:5] opcode = '0;
  logic [0:5] funct = '0;
  logic       zero = 1'b0;
  logic       escritaPC, iouD, leMem, escreveMem, escreveIR;
  logic       memParaReg, regDst, escreveReg, fonteA;
  logic [0:1] fonteB, fontePC;
  logic [0:3] unidadeControle;
  logic       instrInvalida;

  unidade_controle_multiciclo dut (
    .clock(clock), .reset(reset), .opcode(opcode), .funct(funct),
    .zero(zero), .escritaPC(escritaPC), .iouD(iouD), .leMem(leMem),
    .escreveMem(escreveMem), .escreveIR(escreveIR),
    .memParaReg(memParaReg), .regDst(regDst), .escreveReg(escreveReg),
    .fonteA(fonteA), .fonteB(fonteB), .fontePC(fontePC),
    .unidadeControle(unidadeControle), .instrInvalida(instrInvalida)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic       pcw;
    logic       iouD;
    logic       rd;
    logic       wr;
    logic       irw;
    logic       m2r;
    logic       dst;
    logic       rw;
    logic       srcA;
    logic [1:0] srcB;
    logic [1:0] srcPC;
    logic [3:0] alu;
    logic       inv;
  } outs_t;

  outs_t act, exp;
  outs_t hist [0:7];
  bit    chk = 1'b0;
  int    cyc = 0;
  int    nChk = 0;
  int    nPass = 0;
  string tag = "";

  always_comb
    act = '{escritaPC, iouD, leMem, escreveMem, escreveIR, memParaReg,
            regDst, escreveReg, fonteA, fonteB, fontePC, unidadeControle,
            instrInvalida};

  task automatic check(input string nm, input logic [31:0] a,
                       input logic [31:0] e);
    nChk++;
    if (a === e) nPass++;
    else $display("FAIL %s: got %h expected %h", nm, a, e);
  endtask

  function automatic logic [3:0] aluOf(input logic [5:0] fn);
    case (fn)
      6'b100000: return 4'b0010;
      6'b100010: return 4'b0011;
      6'b100100: return 4'b0000;
      6'b100101: return 4'b0001;
      6'b101010: return 4'b0100;
      6'b100111: return 4'b0101;
      default:   return 4'b0010;
    endcase
  endfunction

  function automatic bit fnOk(input logic [5:0] fn);
    return fn inside {6'b100000, 6'b100010, 6'b100100,
                      6'b100101, 6'b101010, 6'b100111};
  endfunction

  function automatic bit opOk(input logic [5:0] op);
    return op inside {6'b100011, 6'b101011, 6'b000000, 6'b000100,
                      6'b000010, 6'b001000} || (BNE && op == 6'b000101);
  endfunction

  // Expected outputs for cycle k of one instruction
  function automatic outs_t model(input int k, input logic [5:0] op,
                                  input logic [5:0] fn, input logic z);
    outs_t o = '0;
    if (k == 0) begin
      o.rd = 1; o.irw = 1; o.srcB = 2'b01; o.alu = 4'b0010; o.pcw = 1;
    end else if (k == 1) begin
      o.srcB = 2'b11; o.alu = 4'b0010; o.inv = !opOk(op);
    end else begin
      case (op)
        6'b100011, 6'b101011: begin
          if (k == 2) begin
            o.srcA = 1; o.srcB = 2'b10; o.alu = 4'b0010;
          end else if (k == 3 && op == 6'b100011) begin
            o.iouD = 1; o.rd = 1;
          end else if (k == 3) begin
            o.iouD = 1; o.wr = 1;
          end else begin
            o.rw = 1; o.m2r = 1;
          end
        end
        6'b000000: begin
          if (k == 2) begin
            o.srcA = 1; o.alu = aluOf(fn);
          end else begin
            o.dst = 1; o.rw = fnOk(fn); o.inv = !fnOk(fn);
          end
        end
        6'b001000: begin
          if (k == 2) begin
            o.srcA = 1; o.srcB = 2'b10; o.alu = 4'b0010;
          end else o.rw = 1;
        end
        6'b000100, 6'b000101: begin
          o.srcA = 1; o.alu = 4'b0011; o.srcPC = 2'b01;
          o.pcw = (op == 6'b000100) ? z : !z;
        end
        6'b000010: begin
          o.srcPC = 2'b10; o.pcw = 1;
        end
        default: o = '0;
      endcase
    end
    return o;
  endfunction

  always @(negedge clock) begin
    if (chk) begin
      hist[cyc] = act;
      check($sformatf("%s c%0d", tag, cyc), 32'(act), 32'(exp));
    end
  end

  // Opcode and funct are scrambled once they must no longer be observed
  task automatic runInstr(input string nm, input logic [5:0] op,
                          input logic [5:0] fn, input logic z, input int n);
    tag = nm;
    for (int k = 0; k < n; k++) begin
      opcode = (k >= 2) ? ~op : op;
      funct  = (k >= 3) ? ~fn : fn;
      zero   = z;
      cyc    = k;
      exp    = model(k, op, fn, z);
      chk    = 1'b1;
      @(posedge clock);
      #1;
    end
    chk = 1'b0;
  endtask

  typedef struct {
    string      nm;
    logic [5:0] op;
    logic [5:0] fn;
    logic       z;
    int         n;
    logic [3:0] aluX;
  } vec_t;

  vec_t vecs [$];

  initial begin
    vecs = '{
      '{"lw",    6'b100011, 6'b000000, 1'b0, 5, 4'b0010},
      '{"sw",    6'b101011, 6'b000000, 1'b0, 4, 4'b0010},
      '{"add",   6'b000000, 6'b100000, 1'b0, 4, 4'b0010},
      '{"sub",   6'b000000, 6'b100010, 1'b0, 4, 4'b0011},
      '{"and",   6'b000000, 6'b100100, 1'b0, 4, 4'b0000},
      '{"or",    6'b000000, 6'b100101, 1'b0, 4, 4'b0001},
      '{"slt",   6'b000000, 6'b101010, 1'b0, 4, 4'b0100},
      '{"nor",   6'b000000, 6'b100111, 1'b0, 4, 4'b0101},
      '{"rbad",  6'b000000, 6'b000000, 1'b0, 4, 4'b0010},
      '{"addi",  6'b001000, 6'b000000, 1'b0, 4, 4'b0010},
      '{"beq1",  6'b000100, 6'b000000, 1'b1, 3, 4'b0011},
      '{"beq0",  6'b000100, 6'b000000, 1'b0, 3, 4'b0011},
      '{"j",     6'b000010, 6'b000000, 1'b0, 3, 4'b0000},
      '{"ilg",   6'b111111, 6'b000000, 1'b0, 2, 4'b0010},
      '{"bne0",  6'b000101, 6'b000000, 1'b0, BNE ? 3 : 2, 4'b0011},
      '{"bne1",  6'b000101, 6'b000000, 1'b1, BNE ? 3 : 2, 4'b0011}
    };

    #1;
    check("reset_outs", 32'(act), 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
    check("post_reset_fetch", {29'd0, leMem, escreveIR, escritaPC}, 32'd7);

    foreach (vecs[i]) begin
      runInstr(vecs[i].nm, vecs[i].op, vecs[i].fn, vecs[i].z, vecs[i].n);
      case (vecs[i].nm)
        "lw": begin
          check("lw_wb", {30'd0, hist[4].rw, hist[4].m2r}, 32'd3);
          check("lw_c3_norw", {31'd0, hist[3].rw}, 32'd0);
          check("lw_addr_alu", {28'd0, hist[2].alu}, 32'h2);
        end
        "rbad": begin
          check("rbad_inv", {31'd0, hist[3].inv}, 32'd1);
          check("rbad_norw", {31'd0, hist[3].rw}, 32'd0);
        end
        "add", "sub", "and", "or", "slt", "nor": begin
          check({vecs[i].nm, "_alu"}, {28'd0, hist[2].alu},
                {28'd0, vecs[i].aluX});
          check({vecs[i].nm, "_fim"}, {30'd0, hist[3].dst, hist[3].rw},
                32'd3);
        end
        "beq1": check("beq1_pc", {29'd0, hist[2].pcw, hist[2].srcPC},
                      32'd5);
        "beq0": check("beq0_pc", {29'd0, hist[2].pcw, hist[2].srcPC},
                      32'd1);
        "j": check("j_pc", {29'd0, hist[2].pcw, hist[2].srcPC}, 32'd6);
        "ilg": check("ilg_inv", {31'd0, hist[1].inv}, 32'd1);
        "bne0": begin
          if (BNE) check("bne0_pcw", {31'd0, hist[2].pcw}, 32'd1);
          else check("bne0_inv", {31'd0, hist[1].inv}, 32'd1);
        end
        default: ;
      endcase
    end

    // Async reset in the middle of ENDMEM of a lw
    runInstr("lw_rst", 6'b100011, 6'b000000, 1'b0, 2);
    opcode = 6'b011100;
    #1;
    check("endmem_before_rst", {31'd0, fonteA}, 32'd1);
    reset = 1'b1;
    #1;
    check("rst_async_outs", 32'(act), 32'd0);
    @(posedge clock);
    #1;
    check("rst_held_outs", 32'(act), 32'd0);
    reset = 1'b0;
    #1;
    check("rst_release_fetch", {29'd0, leMem, escreveIR, escritaPC},
          32'd7);
    runInstr("lw_after", 6'b100011, 6'b000000, 1'b0, 5);
    runInstr("sw_after", 6'b101011, 6'b000000, 1'b0, 4);

    $display("%0d/%0d checks passed", nPass, nChk);
    $finish;
  end

endmodule
